// File: rtl/mem_arb_if.sv
// Bus bundle for the cart-memory arbiter: two requester ports, the memory pin side,
// and status. The arbiter uses the slave modport; requesters/bench use master.
interface mem_arb_if;
  logic        a_req;
  logic        a_we_lo;
  logic        a_we_hi;
  logic [22:0] a_addr;
  logic [15:0] a_dati;
  logic        a_ack;
  logic [15:0] a_dato;

  logic        b_req;
  logic        b_we_lo;
  logic        b_we_hi;
  logic [22:0] b_addr;
  logic [15:0] b_dati;
  logic        b_ack;
  logic [15:0] b_dato;

  logic        m_oe;
  logic        m_we_lo;
  logic        m_we_hi;
  logic [22:0] m_addr;
  logic [15:0] m_dati;
  logic [15:0] m_dato;

  logic        busy;
  logic        owner;

  modport slave (
    input  a_req, a_we_lo, a_we_hi, a_addr, a_dati,
    input  b_req, b_we_lo, b_we_hi, b_addr, b_dati,
    input  m_dato,
    output a_ack, a_dato, b_ack, b_dato,
    output m_oe, m_we_lo, m_we_hi, m_addr, m_dati,
    output busy, owner
  );

  modport master (
    output a_req, a_we_lo, a_we_hi, a_addr, a_dati,
    output b_req, b_we_lo, b_we_hi, b_addr, b_dati,
    output m_dato,
    input  a_ack, a_dato, b_ack, b_dato,
    input  m_oe, m_we_lo, m_we_hi, m_addr, m_dati,
    input  busy, owner
  );
endinterface

// File: rtl/mem_arb.sv
// Two-port arbiter and access sequencer for the external 16-bit cart memory.
// Fixed-length strobes plus recovery, starvation guard for port B, falling-edge state.
module mem_arb #(
  parameter int ACC_CYC  = 4,
  parameter int REC_CYC  = 1,
  parameter int MAX_WAIT = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  mem_arb_if.slave  bus
);

  localparam int CMAX = (ACC_CYC > REC_CYC) ? ACC_CYC : REC_CYC;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int SW   = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;

  state_t        r_state, w_state;
  logic [CW-1:0] r_cyc, w_cyc;
  logic [SW-1:0] r_starve, w_starve;
  logic          r_oe, w_oe;
  logic          r_we_lo, w_we_lo;
  logic          r_we_hi, w_we_hi;
  logic [22:0]   r_addr, w_addr;
  logic [15:0]   r_dati, w_dati;
  logic          r_a_ack, w_a_ack;
  logic          r_b_ack, w_b_ack;
  logic [15:0]   r_a_dato, w_a_dato;
  logic [15:0]   r_b_dato, w_b_dato;
  logic          r_busy, w_busy;
  logic          r_owner, w_owner;

  logic w_a_elig, w_b_elig, w_grant_a, w_grant_b;

  // A port still holding req during its own ack pulse is not re-granted.
  assign w_a_elig  = bus.a_req & ~r_a_ack;
  assign w_b_elig  = bus.b_req & ~r_b_ack;
  assign w_grant_b = (r_state == IDLE) & w_b_elig &
                     ((r_starve == SW'(MAX_WAIT)) | ~w_a_elig);
  assign w_grant_a = (r_state == IDLE) & w_a_elig & ~w_grant_b;

  always_comb begin
    w_state  = r_state;
    w_cyc    = r_cyc;
    w_starve = r_starve;
    w_oe     = r_oe;
    w_we_lo  = r_we_lo;
    w_we_hi  = r_we_hi;
    w_addr   = r_addr;
    w_dati   = r_dati;
    w_a_ack  = 1'b0;
    w_b_ack  = 1'b0;
    w_a_dato = r_a_dato;
    w_b_dato = r_b_dato;
    w_busy   = r_busy;
    w_owner  = r_owner;
    case (r_state)
      IDLE: begin
        if (w_grant_b) begin
          w_state  = ACCESS;
          w_busy   = 1'b1;
          w_owner  = 1'b1;
          w_cyc    = CW'(ACC_CYC - 1);
          w_addr   = bus.b_addr;
          w_dati   = bus.b_dati;
          w_we_lo  = bus.b_we_lo;
          w_we_hi  = bus.b_we_hi;
          w_oe     = ~(bus.b_we_lo | bus.b_we_hi);
          w_starve = '0;
        end else if (w_grant_a) begin
          w_state  = ACCESS;
          w_busy   = 1'b1;
          w_owner  = 1'b0;
          w_cyc    = CW'(ACC_CYC - 1);
          w_addr   = bus.a_addr;
          w_dati   = bus.a_dati;
          w_we_lo  = bus.a_we_lo;
          w_we_hi  = bus.a_we_hi;
          w_oe     = ~(bus.a_we_lo | bus.a_we_hi);
          if (!bus.b_req)
            w_starve = '0;
          else if (r_starve != SW'(MAX_WAIT))
            w_starve = r_starve + 1'b1;
        end
      end
      ACCESS: begin
        if (r_cyc == '0) begin
          w_oe    = 1'b0;
          w_we_lo = 1'b0;
          w_we_hi = 1'b0;
          if (r_owner) begin
            w_b_ack = 1'b1;
            if (r_oe) w_b_dato = bus.m_dato;
          end else begin
            w_a_ack = 1'b1;
            if (r_oe) w_a_dato = bus.m_dato;
          end
          if (REC_CYC > 0) begin
            w_state = RECOVER;
            w_cyc   = CW'((REC_CYC > 0) ? REC_CYC - 1 : 0);
          end else begin
            w_state = IDLE;
            w_busy  = 1'b0;
          end
        end else begin
          w_cyc = r_cyc - 1'b1;
        end
      end
      RECOVER: begin
        if (r_cyc == '0) begin
          w_state = IDLE;
          w_busy  = 1'b0;
        end else begin
          w_cyc = r_cyc - 1'b1;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cyc    <= '0;
      r_starve <= '0;
      r_oe     <= 1'b0;
      r_we_lo  <= 1'b0;
      r_we_hi  <= 1'b0;
      r_addr   <= '0;
      r_dati   <= '0;
      r_a_ack  <= 1'b0;
      r_b_ack  <= 1'b0;
      r_a_dato <= '0;
      r_b_dato <= '0;
      r_busy   <= 1'b0;
      r_owner  <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cyc    <= w_cyc;
      r_starve <= w_starve;
      r_oe     <= w_oe;
      r_we_lo  <= w_we_lo;
      r_we_hi  <= w_we_hi;
      r_addr   <= w_addr;
      r_dati   <= w_dati;
      r_a_ack  <= w_a_ack;
      r_b_ack  <= w_b_ack;
      r_a_dato <= w_a_dato;
      r_b_dato <= w_b_dato;
      r_busy   <= w_busy;
      r_owner  <= w_owner;
    end
  end

  assign bus.m_oe    = r_oe;
  assign bus.m_we_lo = r_we_lo;
  assign bus.m_we_hi = r_we_hi;
  assign bus.m_addr  = r_addr;
  assign bus.m_dati  = r_dati;
  assign bus.a_ack   = r_a_ack;
  assign bus.b_ack   = r_b_ack;
  assign bus.a_dato  = r_a_dato;
  assign bus.b_dato  = r_b_dato;
  assign bus.busy    = r_busy;
  assign bus.owner   = r_owner;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: three instances cover default timing, starvation
// (MAX_WAIT=3) and zero-recovery hold-after-ack behaviour.
module tb_mem_arb;
  logic clk;
  logic rst_n;
  int   nTests = 0;
  int   nFail  = 0;

  logic expOwner [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  int   expStarve[5] = '{1, 2, 3, 0, 1};

  mem_arb_if if0 ();
  mem_arb_if if1 ();
  mem_arb_if if2 ();

  mem_arb #(.ACC_CYC(4), .REC_CYC(1), .MAX_WAIT(8)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  mem_arb #(.ACC_CYC(2), .REC_CYC(1), .MAX_WAIT(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  mem_arb #(.ACC_CYC(2), .REC_CYC(0), .MAX_WAIT(8)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // DUT state moves on negedge; the bench samples and drives just after posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int dut, input bit port, input logic req,
                               input logic weLo, input logic weHi,
                               input logic [22:0] addr, input logic [15:0] dati);
    case ({dut[1:0], port})
      3'b000: begin if0.a_req = req; if0.a_we_lo = weLo; if0.a_we_hi = weHi; if0.a_addr = addr; if0.a_dati = dati; end
      3'b001: begin if0.b_req = req; if0.b_we_lo = weLo; if0.b_we_hi = weHi; if0.b_addr = addr; if0.b_dati = dati; end
      3'b010: begin if1.a_req = req; if1.a_we_lo = weLo; if1.a_we_hi = weHi; if1.a_addr = addr; if1.a_dati = dati; end
      3'b011: begin if1.b_req = req; if1.b_we_lo = weLo; if1.b_we_hi = weHi; if1.b_addr = addr; if1.b_dati = dati; end
      3'b100: begin if2.a_req = req; if2.a_we_lo = weLo; if2.a_we_hi = weHi; if2.a_addr = addr; if2.a_dati = dati; end
      default: begin if2.b_req = req; if2.b_we_lo = weLo; if2.b_we_hi = weHi; if2.b_addr = addr; if2.b_dati = dati; end
    endcase
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      applyStimulus(d, 1'b0, 1'b0, 1'b0, 1'b0, 23'h0, 16'h0);
      applyStimulus(d, 1'b1, 1'b0, 1'b0, 1'b0, 23'h0, 16'h0);
    end
    if0.m_dato = 16'h0;
    if1.m_dato = 16'h0;
    if2.m_dato = 16'h0;
    tick();
    checkOutput("rst_oe",    32'(if0.m_oe),   32'h0);
    checkOutput("rst_busy",  32'(if0.busy),   32'h0);
    checkOutput("rst_owner", 32'(if0.owner),  32'h0);
    checkOutput("rst_addr",  32'(if0.m_addr), 32'h0);
    checkOutput("rst_adato", 32'(if0.a_dato), 32'h0);
    checkOutput("rst_ack",   32'(if0.a_ack),  32'h0);
    rst_n = 1'b1;

    // Port A read: 4 strobe clocks, ack next, busy drops after recovery
    if0.m_dato = 16'hBEEF;
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0, 23'h000100, 16'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("rdA_oe",   32'(if0.m_oe),   32'h1);
      checkOutput("rdA_addr", 32'(if0.m_addr), 32'h100);
      checkOutput("rdA_noack", 32'(if0.a_ack), 32'h0);
    end
    tick();
    checkOutput("rdA_ack",   32'(if0.a_ack),  32'h1);
    checkOutput("rdA_dato",  32'(if0.a_dato), 32'hBEEF);
    checkOutput("rdA_oeoff", 32'(if0.m_oe),   32'h0);
    checkOutput("rdA_busy1", 32'(if0.busy),   32'h1);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, 23'h0, 16'h0);
    tick();
    checkOutput("rdA_ackend", 32'(if0.a_ack),  32'h0);
    checkOutput("rdA_busy0",  32'(if0.busy),   32'h0);
    checkOutput("rdA_hold",   32'(if0.m_addr), 32'h100);

    // Simultaneous requests: A first, B six clocks later
    if0.m_dato = 16'h1111;
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0, 23'h000200, 16'h0);
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b0, 23'h000300, 16'h0);
    tick();
    checkOutput("sim_ownA", 32'(if0.owner),  32'h0);
    checkOutput("sim_addrA", 32'(if0.m_addr), 32'h200);
    checkOutput("sim_oeA",  32'(if0.m_oe),   32'h1);
    repeat (3) tick();
    tick();
    checkOutput("sim_ackA",  32'(if0.a_ack),  32'h1);
    checkOutput("sim_datoA", 32'(if0.a_dato), 32'h1111);
    checkOutput("sim_noackB", 32'(if0.b_ack), 32'h0);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, 23'h0, 16'h0);
    if0.m_dato = 16'h2222;
    tick();
    checkOutput("sim_gap_busy",  32'(if0.busy),  32'h0);
    checkOutput("sim_gap_owner", 32'(if0.owner), 32'h0);
    tick();
    checkOutput("sim_ownB",  32'(if0.owner),  32'h1);
    checkOutput("sim_addrB", 32'(if0.m_addr), 32'h300);
    checkOutput("sim_oeB",   32'(if0.m_oe),   32'h1);
    repeat (3) tick();
    tick();
    checkOutput("sim_ackB",  32'(if0.b_ack),  32'h1);
    checkOutput("sim_datoB", 32'(if0.b_dato), 32'h2222);
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0, 23'h0, 16'h0);
    tick();
    checkOutput("sim_end_busy", 32'(if0.busy), 32'h0);

    // Port B high-byte write, odd address passes through
    if0.m_dato = 16'h5555;
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b1, 23'h000401, 16'h12AB);
    tick();
    checkOutput("wr_wehi", 32'(if0.m_we_hi), 32'h1);
    checkOutput("wr_welo", 32'(if0.m_we_lo), 32'h0);
    checkOutput("wr_oe",   32'(if0.m_oe),    32'h0);
    checkOutput("wr_dati", 32'(if0.m_dati),  32'h12AB);
    checkOutput("wr_addr", 32'(if0.m_addr),  32'h401);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("wr_wehi_held", 32'(if0.m_we_hi), 32'h1);
    end
    tick();
    checkOutput("wr_ack",     32'(if0.b_ack),   32'h1);
    checkOutput("wr_dato",    32'(if0.b_dato),  32'h2222);
    checkOutput("wr_wehioff", 32'(if0.m_we_hi), 32'h0);
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0, 23'h0, 16'h0);
    tick();
    checkOutput("wr_busy0", 32'(if0.busy), 32'h0);

    // Async reset in the second access clock, then a fresh request
    if0.m_dato = 16'h7777;
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0, 23'h000500, 16'h0);
    tick();
    checkOutput("ar_oe_on", 32'(if0.m_oe), 32'h1);
    tick();
    #1 rst_n = 1'b0;
    #1;
    checkOutput("ar_oe_drop",   32'(if0.m_oe),   32'h0);
    checkOutput("ar_busy_drop", 32'(if0.busy),   32'h0);
    checkOutput("ar_addr_clr",  32'(if0.m_addr), 32'h0);
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0, 23'h000600, 16'h0);
    tick();
    checkOutput("ar_noack", 32'(if0.a_ack), 32'h0);
    checkOutput("ar_oe_in_rst", 32'(if0.m_oe), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("ar_new_oe",    32'(if0.m_oe),   32'h1);
      checkOutput("ar_new_addr",  32'(if0.m_addr), 32'h600);
      checkOutput("ar_new_noack", 32'(if0.a_ack),  32'h0);
    end
    tick();
    checkOutput("ar_new_ack",  32'(if0.a_ack),  32'h1);
    checkOutput("ar_new_dato", 32'(if0.a_dato), 32'h7777);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, 23'h0, 16'h0);
    tick();

    // Starvation guard with MAX_WAIT=3: order A,A,A,B,A
    applyStimulus(1, 1'b0, 1'b1, 1'b0, 1'b0, 23'h000A00, 16'h0);
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 1'b0, 23'h000B00, 16'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("stv_owner", 32'(if1.owner), 32'(expOwner[i]));
      checkOutput("stv_addr",  32'(if1.m_addr), expOwner[i] ? 32'hB00 : 32'hA00);
      checkOutput("stv_ctr",   32'(dut1.r_starve), 32'(expStarve[i]));
      repeat (3) tick();
    end
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b0, 23'h0, 16'h0);
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 1'b0, 23'h0, 16'h0);
    repeat (3) tick();
    checkOutput("stv_idle", 32'(if1.busy), 32'h0);

    // REC_CYC=0: no re-grant in the ack cycle, next grant right after
    if2.m_dato = 16'h3C3C;
    applyStimulus(2, 1'b0, 1'b1, 1'b0, 1'b0, 23'h000C00, 16'h0);
    tick();
    checkOutput("hold_oe1", 32'(if2.m_oe), 32'h1);
    tick();
    checkOutput("hold_oe2", 32'(if2.m_oe), 32'h1);
    tick();
    checkOutput("hold_ack",  32'(if2.a_ack),  32'h1);
    checkOutput("hold_oe3",  32'(if2.m_oe),   32'h0);
    checkOutput("hold_busy", 32'(if2.busy),   32'h0);
    checkOutput("hold_dato", 32'(if2.a_dato), 32'h3C3C);
    tick();
    checkOutput("hold_noregrant", 32'(if2.m_oe),  32'h0);
    checkOutput("hold_ackend",    32'(if2.a_ack), 32'h0);
    tick();
    checkOutput("hold_regrant_oe",   32'(if2.m_oe),   32'h1);
    checkOutput("hold_regrant_busy", 32'(if2.busy),   32'h1);
    checkOutput("hold_regrant_addr", 32'(if2.m_addr), 32'hC00);
    applyStimulus(2, 1'b0, 1'b0, 1'b0, 1'b0, 23'h0, 16'h0);
    tick();
    checkOutput("hold_drop_oe", 32'(if2.m_oe), 32'h1);
    tick();
    checkOutput("hold_drop_ack", 32'(if2.a_ack), 32'h1);
    tick();
    checkOutput("hold_final_ack",  32'(if2.a_ack), 32'h0);
    checkOutput("hold_final_busy", 32'(if2.busy),  32'h0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
